// File: rtl/ysyx_220053_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - ifu_state_e      : fetch FSM states (StHalt only with IFU_MISALIGN_CHK_EN)
//   - RESET_PC_DEFAULT : default PC of the first fetch after reset
//   - NOP_INSTR        : instruction presented while halted on a misaligned target
//   - INSTR_BYTES      : PC increment per instruction
// Config macro: IFU_MISALIGN_CHK_EN adds the HALT state.
package ysyx_220053_ifu_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES      = 4;

    typedef enum logic [2:0] {
        StReq,
        StWait,
        StDrain,
        StHold
`ifdef IFU_MISALIGN_CHK_EN
        ,
        StHalt
`endif
    } ifu_state_e;

endpackage

// File: rtl/ysyx_220053_ifu_pcgen.sv
// PC register with next-PC selection: reset > redirect > advance (+4) > hold.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   redirect_valid_i  load redirect_pc_i next cycle
//   redirect_pc_i     redirect target
//   advance_i         current instruction consumed, step to the next one
//   cur_pc_o          current fetch PC
module ysyx_220053_ifu_pcgen
    import ysyx_220053_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] cur_pc_o
);

    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            // Wraps modulo 2^XLEN by construction.
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign cur_pc_o = pc_q;

endmodule

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch stage: one outstanding 32-bit fetch, result held on a valid/ready
// output to decode. A redirect may arrive at any time; a fetch in flight is drained and dropped.
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   imem_req_valid/ready/addr            fetch request channel (addr = current PC)
//   imem_rsp_valid/data                  fetch response, one per accepted request
//   redirect_valid/redirect_pc           new PC, kills anything fetched or in flight
//   instr_valid/instr_ready/instr_o/pc_o output to decode
//   fetch_err                            misaligned target halt flag (IFU_MISALIGN_CHK_EN only)
// Config macro: IFU_MISALIGN_CHK_EN enables the alignment check, HALT state and fetch_err.
module ysyx_220053_ifu
    import ysyx_220053_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic            fetch_err
`endif
);

    ifu_state_e      state_q, state_d;
    logic            instr_valid_q, instr_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] pc;
    logic            req_fire;
    logic            advance;
    logic            misaligned;

    // Only a consumed instruction steps the PC; a redirect in the same cycle wins.
    assign advance = (state_q == StHold) && instr_ready && !redirect_valid;

    ysyx_220053_ifu_pcgen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pcgen (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (advance),
        .cur_pc_o         (pc)
    );

`ifdef IFU_MISALIGN_CHK_EN
    logic fetch_err_q, fetch_err_d;
    assign misaligned = (pc[1:0] != 2'b00);
    assign fetch_err  = fetch_err_q;
`else
    assign misaligned = 1'b0;
`endif

    assign imem_req_valid = rst_n && (state_q == StReq) && !misaligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
`ifdef IFU_MISALIGN_CHK_EN
        fetch_err_d   = fetch_err_q;
`endif
        case (state_q)
            StReq: begin
                if (redirect_valid) begin
                    // An accepted request now has a response coming that must be dropped.
                    state_d = req_fire ? StDrain : StReq;
                end
`ifdef IFU_MISALIGN_CHK_EN
                else if (misaligned) begin
                    state_d       = StHalt;
                    instr_valid_d = 1'b1;
                    instr_d       = NOP_INSTR;
                    pc_out_d      = pc;
                    fetch_err_d   = 1'b1;
                end
`endif
                else if (req_fire) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? StReq : StDrain;
                end else if (imem_rsp_valid) begin
                    state_d       = StHold;
                    instr_valid_d = 1'b1;
                    instr_d       = imem_rsp_data;
                    pc_out_d      = pc;
                end
            end
            StHold: begin
                if (redirect_valid || instr_ready) begin
                    state_d       = StReq;
                    instr_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (imem_rsp_valid) begin
                    state_d = StReq;
                end
            end
`ifdef IFU_MISALIGN_CHK_EN
            StHalt: begin
                if (redirect_valid) begin
                    state_d       = StReq;
                    instr_valid_d = 1'b0;
                    fetch_err_d   = 1'b0;
                end
            end
`endif
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StReq;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            pc_out_q      <= RESET_PC;
`ifdef IFU_MISALIGN_CHK_EN
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
`ifdef IFU_MISALIGN_CHK_EN
            fetch_err_q   <= fetch_err_d;
`endif
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr_o     = instr_q;
    assign pc_o        = pc_out_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Randomized bench: a behavioural memory returns a fixed word per address after 1-3 cycles;
// the reference tracks the architectural PC (reset, +4 per consumed instruction, redirect
// target) and checks requests, output words, hand-shake stability and one-outstanding rule.
module tb_ysyx_220053_ifu;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
`ifdef IFU_MISALIGN_CHK_EN
    logic        fetch_err;
`endif

    always #5 clk = ~clk;

    ysyx_220053_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_o        (instr_o),
        .pc_o           (pc_o)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .fetch_err      (fetch_err)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned consumed = 0;
    int          cyc      = 0;

    // Memory model: pending responses (address, cycle at which it may be returned).
    logic [63:0] q_addr[$];
    int          q_due[$];
    logic        rsp_real = 1'b0;

    // Reference state.
    logic [63:0] exp_pc = RESET_PC;
    logic        prev_rst_low = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_leave = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic [63:0] prev_pc = 64'h0;
    logic        prev_req_hold = 1'b0;
    logic [63:0] prev_addr = 64'h0;
`ifdef IFU_MISALIGN_CHK_EN
    logic        prev_misal = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0513;
    endfunction

    function automatic logic [63:0] pick_target();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef IFU_MISALIGN_CHK_EN
        if (r == 1) return RESET_PC + 64'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
`endif
        return RESET_PC + 64'($urandom_range(0, 1023) * 4);
    endfunction

    task automatic evaluate();
        logic aligned;
        if (!rst_n) begin
            check_eq("rst_req_valid", imem_req_valid, 64'd0);
            if (prev_rst_low) begin
                check_eq("rst_instr_valid", instr_valid, 64'd0);
                check_eq("rst_instr_o", instr_o, 64'd0);
                check_eq("rst_pc_o", pc_o, RESET_PC);
`ifdef IFU_MISALIGN_CHK_EN
                check_eq("rst_fetch_err", fetch_err, 64'd0);
                prev_misal = 1'b0;
`endif
            end
            q_addr.delete();
            q_due.delete();
            exp_pc        = RESET_PC;
            prev_valid    = 1'b0;
            prev_req_hold = 1'b0;
            prev_rst_low  = 1'b1;
            return;
        end
        if (prev_rst_low) begin
            check_eq("first_req_valid", imem_req_valid, 64'd1);
            check_eq("first_req_addr", imem_req_addr, RESET_PC);
        end
        prev_rst_low = 1'b0;
        aligned = (exp_pc[1:0] == 2'b00);

        if (prev_valid && !prev_leave) begin
            check_eq("hold_valid", instr_valid, 64'd1);
            check_eq("hold_instr", instr_o, prev_instr);
            check_eq("hold_pc", pc_o, prev_pc);
        end
        if (prev_req_hold) begin
            check_eq("req_hold_valid", imem_req_valid, 64'd1);
            check_eq("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (instr_valid) begin
            check_eq("out_pc", pc_o, exp_pc);
            check_eq("out_instr", instr_o, aligned ? mem_word(exp_pc) : NOP);
        end
`ifdef IFU_MISALIGN_CHK_EN
        check_eq("fetch_err", fetch_err, 64'(instr_valid && !aligned));
        if (!aligned) check_eq("misal_no_req", imem_req_valid, 64'd0);
        if (prev_misal) check_eq("halt_valid", instr_valid, 64'd1);
        prev_misal = !aligned && !redirect_valid;
`endif

        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_addr, exp_pc);
            check_eq("one_outstanding", 64'(q_addr.size()), 64'd0);
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + int'($urandom_range(1, 3)));
        end
        if (rsp_real) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end

        prev_valid    = instr_valid;
        prev_instr    = instr_o;
        prev_pc       = pc_o;
        prev_leave    = redirect_valid || (instr_ready && aligned);
        prev_req_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr     = imem_req_addr;

        if (redirect_valid) begin
            exp_pc = redirect_pc;
        end else if (instr_valid && instr_ready && aligned) begin
            exp_pc = exp_pc + 64'd4;
            consumed++;
        end
    endtask

    task automatic step(input logic rst_val);
        @(posedge clk);
        #1;
        cyc++;
        rst_n    = rst_val;
        rsp_real = 1'b0;
        if (q_addr.size() != 0 && cyc >= q_due[0]) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
            rsp_real       = 1'b1;
        end else if (q_addr.size() == 0 && $urandom_range(0, 7) == 0) begin
            // Stray response with nothing outstanding; must be ignored.
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 9) < 7);
        instr_ready    = ($urandom_range(0, 9) < 6);
        redirect_valid = rst_val && ($urandom_range(0, 19) == 0);
        redirect_pc    = pick_target();
        @(negedge clk);
        evaluate();
    endtask

    initial begin
        repeat (3) step(1'b0);
        repeat (1500) step(1'b1);
        repeat (3) step(1'b0);
        repeat (1500) step(1'b1);
        check_eq("progress", 64'(consumed > 150), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
